// File: rtl/weight_tile_fifo_pkg.sv
// Shared types and size helpers for the weight tile FIFO.
package weight_tile_pkg;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_RUN  = 1'b1
  } drain_state_t;

  typedef enum logic {
    B_FREE = 1'b0,
    B_FULL = 1'b1
  } bank_state_t;

  // Number of elements in one tile.
  function automatic int elems(input int n_cols, input int tile_rows);
    return n_cols * tile_rows;
  endfunction

  // Cycles from first to last skewed output of one drain.
  function automatic int drain_len(input int n_cols, input int tile_rows);
    return tile_rows + n_cols - 1;
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_tile_fifo_if.sv
// Load/drain bus of the weight tile FIFO.
interface weight_tile_fifo_if #(
  parameter int N_COLS = 4,
  parameter int DATA_W = 8
);
  logic                     flush;
  logic                     wr_valid;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ready;
  logic                     pop_start;
  logic [N_COLS*DATA_W-1:0] col_data;
  logic [N_COLS-1:0]        col_valid;
  logic                     pop_busy;
  logic                     pop_done;
  logic                     pop_err;
  logic [1:0]               tiles_avail;

  modport master (
    output flush, wr_valid, wr_data, pop_start,
    input  wr_ready, col_data, col_valid, pop_busy, pop_done, pop_err, tiles_avail
  );

  modport slave (
    input  flush, wr_valid, wr_data, pop_start,
    output wr_ready, col_data, col_valid, pop_busy, pop_done, pop_err, tiles_avail
  );
endinterface

// File: rtl/weight_tile_fifo_bank.sv
// One tile bank: ROWS x COLS element registers, element write, per-column read.
module tile_bank #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ROW_W-1:0]       wr_row,
  input  logic [COL_W-1:0]       wr_col,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [COLS*ROW_W-1:0]  rd_row,
  output logic [COLS*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [ROWS][COLS];

  // Element storage: one element written per accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_r[r][c] <= {DATA_W{1'b0}};
        end
      end
    end else if (wr_en) begin
      mem_r[wr_row][wr_col] <= wr_data;
    end
  end

  // Column k reads the row selected by its own row index.
  always_comb begin
    rd_data = {COLS*DATA_W{1'b0}};
    for (int k = 0; k < COLS; k++) begin
      rd_data[k*DATA_W +: DATA_W] = mem_r[rd_row[k*ROW_W +: ROW_W]][k];
    end
  end

endmodule

// File: rtl/weight_tile_fifo.sv
// Ping-pong weight tile FIFO: packs a byte stream into tiles and drains
// one tile at a time into the systolic columns with diagonal skew.
module weight_tile_fifo
  import weight_tile_pkg::*;
#(
  parameter int N_COLS    = 4,
  parameter int TILE_ROWS = 4,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  weight_tile_fifo_if.slave bus
);

  localparam int ELEMS     = elems(N_COLS, TILE_ROWS);
  localparam int DRAIN_LEN = drain_len(N_COLS, TILE_ROWS);
  localparam int ROW_W     = idx_w(TILE_ROWS);
  localparam int COL_W     = idx_w(N_COLS);
  localparam int CNT_W     = idx_w(DRAIN_LEN);
  localparam int EL_W      = idx_w(ELEMS);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TILE_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_LEN - 1);
  localparam logic [EL_W-1:0]  LAST_EL  = EL_W'(ELEMS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [EL_W-1:0]  EL_ONE   = EL_W'(1);

  // Fill side state
  bank_state_t              bank_state_r [2];
  logic                     fill_bank_r;
  logic                     drain_bank_r;
  logic [EL_W-1:0]          elem_cnt_r;
  logic [ROW_W-1:0]         wr_row_r;
  logic [COL_W-1:0]         wr_col_r;
  logic [1:0]               tiles_avail_r;

  // Drain side state and registered outputs
  drain_state_t             state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [N_COLS*DATA_W-1:0] col_data_r;
  logic [N_COLS-1:0]        col_valid_r;
  logic                     pop_busy_r;
  logic                     pop_done_r;
  logic                     pop_err_r;

  // Combinational decisions
  logic                     wr_ready_s;
  logic                     wr_fire_s;
  logic                     commit_s;
  logic [1:0]               wr_en_s;
  logic                     start_s;
  logic                     done_s;
  logic                     err_s;
  logic                     run_nxt_s;
  logic [CNT_W-1:0]         cnt_nxt_s;
  logic [N_COLS*ROW_W-1:0]  rd_row_s;
  logic [N_COLS-1:0]        tap_valid_s;
  logic [N_COLS*DATA_W-1:0] rd_data0_s;
  logic [N_COLS*DATA_W-1:0] rd_data1_s;
  logic [N_COLS*DATA_W-1:0] rd_sel_s;
  logic [N_COLS*DATA_W-1:0] col_data_nxt_s;

  // Write acceptance: only into a free fill bank, never while resetting or flushing.
  always_comb begin
    wr_ready_s = !rst && !bus.flush && (bank_state_r[fill_bank_r] == B_FREE);
    wr_fire_s  = bus.wr_valid && wr_ready_s;
    commit_s   = wr_fire_s && (elem_cnt_r == LAST_EL);
    wr_en_s[0] = wr_fire_s && (fill_bank_r == 1'b0);
    wr_en_s[1] = wr_fire_s && (fill_bank_r == 1'b1);
  end

  // Drain decisions; the cycle counter value for the next cycle drives skew addressing.
  always_comb begin
    start_s   = 1'b0;
    done_s    = 1'b0;
    err_s     = 1'b0;
    run_nxt_s = 1'b0;
    cnt_nxt_s = {CNT_W{1'b0}};
    if (bus.flush) begin
      run_nxt_s = 1'b0;
    end else begin
      case (state_r)
        D_IDLE: begin
          if (bus.pop_start) begin
            if (tiles_avail_r != 2'd0) begin
              start_s   = 1'b1;
              run_nxt_s = 1'b1;
            end else begin
              err_s = 1'b1;
            end
          end else begin
            run_nxt_s = 1'b0;
          end
        end
        D_RUN: begin
          err_s = bus.pop_start;
          if (cnt_r == LAST_CNT) begin
            done_s = 1'b1;
          end else begin
            run_nxt_s = 1'b1;
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          run_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Skew addressing: column k shows row (cnt - k) while that row is inside the tile.
  always_comb begin
    int diff;
    diff        = 0;
    rd_row_s    = {N_COLS*ROW_W{1'b0}};
    tap_valid_s = {N_COLS{1'b0}};
    for (int k = 0; k < N_COLS; k++) begin
      diff = int'(cnt_nxt_s) - k;
      if (run_nxt_s && (diff >= 0) && (diff < TILE_ROWS)) begin
        tap_valid_s[k]                 = 1'b1;
        rd_row_s[k*ROW_W +: ROW_W]     = ROW_W'(diff);
      end else begin
        tap_valid_s[k]                 = 1'b0;
        rd_row_s[k*ROW_W +: ROW_W]     = {ROW_W{1'b0}};
      end
    end
  end

  // Select the draining bank and zero every column outside its window.
  always_comb begin
    rd_sel_s       = drain_bank_r ? rd_data1_s : rd_data0_s;
    col_data_nxt_s = {N_COLS*DATA_W{1'b0}};
    for (int k = 0; k < N_COLS; k++) begin
      if (tap_valid_s[k]) begin
        col_data_nxt_s[k*DATA_W +: DATA_W] = rd_sel_s[k*DATA_W +: DATA_W];
      end else begin
        col_data_nxt_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  tile_bank #(
    .ROWS(TILE_ROWS), .COLS(N_COLS), .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)
  ) u_bank0 (
    .clk(clk), .rst(rst), .wr_en(wr_en_s[0]), .wr_row(wr_row_r), .wr_col(wr_col_r),
    .wr_data(bus.wr_data), .rd_row(rd_row_s), .rd_data(rd_data0_s)
  );

  tile_bank #(
    .ROWS(TILE_ROWS), .COLS(N_COLS), .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)
  ) u_bank1 (
    .clk(clk), .rst(rst), .wr_en(wr_en_s[1]), .wr_row(wr_row_r), .wr_col(wr_col_r),
    .wr_data(bus.wr_data), .rd_row(rd_row_s), .rd_data(rd_data1_s)
  );

  // Fill pointers, bank occupancy and committed-tile count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state_r[0] <= B_FREE;
      bank_state_r[1] <= B_FREE;
      fill_bank_r     <= 1'b0;
      drain_bank_r    <= 1'b0;
      elem_cnt_r      <= {EL_W{1'b0}};
      wr_row_r        <= {ROW_W{1'b0}};
      wr_col_r        <= {COL_W{1'b0}};
      tiles_avail_r   <= 2'd0;
    end else if (bus.flush) begin
      bank_state_r[0] <= B_FREE;
      bank_state_r[1] <= B_FREE;
      fill_bank_r     <= 1'b0;
      drain_bank_r    <= 1'b0;
      elem_cnt_r      <= {EL_W{1'b0}};
      wr_row_r        <= {ROW_W{1'b0}};
      wr_col_r        <= {COL_W{1'b0}};
      tiles_avail_r   <= 2'd0;
    end else begin
      if (wr_fire_s) begin
        elem_cnt_r <= commit_s ? {EL_W{1'b0}} : (elem_cnt_r + EL_ONE);
        if (wr_col_r == LAST_COL) begin
          wr_col_r <= {COL_W{1'b0}};
          wr_row_r <= (wr_row_r == LAST_ROW) ? {ROW_W{1'b0}} : (wr_row_r + ROW_ONE);
        end else begin
          wr_col_r <= wr_col_r + COL_ONE;
        end
      end
      if (commit_s) begin
        fill_bank_r <= ~fill_bank_r;
      end
      if (done_s) begin
        drain_bank_r <= ~drain_bank_r;
      end
      for (int b = 0; b < 2; b++) begin
        if (commit_s && (fill_bank_r == 1'(b))) begin
          bank_state_r[b] <= B_FULL;
        end else if (done_s && (drain_bank_r == 1'(b))) begin
          bank_state_r[b] <= B_FREE;
        end
      end
      case ({commit_s, done_s})
        2'b10:   tiles_avail_r <= tiles_avail_r + 2'd1;
        2'b01:   tiles_avail_r <= tiles_avail_r - 2'd1;
        default: tiles_avail_r <= tiles_avail_r;
      endcase
    end
  end

  // Drain FSM with registered skewed column outputs and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= D_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      col_data_r  <= {N_COLS*DATA_W{1'b0}};
      col_valid_r <= {N_COLS{1'b0}};
      pop_busy_r  <= 1'b0;
      pop_done_r  <= 1'b0;
      pop_err_r   <= 1'b0;
    end else if (bus.flush) begin
      state_r     <= D_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      col_data_r  <= {N_COLS*DATA_W{1'b0}};
      col_valid_r <= {N_COLS{1'b0}};
      pop_busy_r  <= 1'b0;
      pop_done_r  <= 1'b0;
      pop_err_r   <= 1'b0;
    end else begin
      case (state_r)
        D_IDLE:  state_r <= start_s ? D_RUN : D_IDLE;
        D_RUN:   state_r <= done_s ? D_IDLE : D_RUN;
        default: state_r <= D_IDLE;
      endcase
      cnt_r       <= cnt_nxt_s;
      col_data_r  <= col_data_nxt_s;
      col_valid_r <= tap_valid_s;
      pop_busy_r  <= run_nxt_s;
      pop_done_r  <= done_s;
      pop_err_r   <= err_s;
    end
  end

  assign bus.wr_ready    = wr_ready_s;
  assign bus.col_data    = col_data_r;
  assign bus.col_valid   = col_valid_r;
  assign bus.pop_busy    = pop_busy_r;
  assign bus.pop_done    = pop_done_r;
  assign bus.pop_err     = pop_err_r;
  assign bus.tiles_avail = tiles_avail_r;

endmodule

// File: tb/tb_weight_tile_fifo.sv
// Randomised bench for weight_tile_fifo against a queue-based tile model.
module tb_weight_tile_fifo;

  localparam int N_COLS    = 4;
  localparam int TILE_ROWS = 4;
  localparam int DATA_W    = 8;
  localparam int ELEMS     = N_COLS * TILE_ROWS;
  localparam int DRAIN_LEN = TILE_ROWS + N_COLS - 1;

  logic clk;
  logic rst;

  weight_tile_fifo_if #(.N_COLS(N_COLS), .DATA_W(DATA_W)) bus ();

  weight_tile_fifo #(.N_COLS(N_COLS), .TILE_ROWS(TILE_ROWS), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: committed tiles in arrival order, plus the partial tile.
  logic [DATA_W-1:0] tile_q [$];
  logic [DATA_W-1:0] part_q [$];
  int cyc;
  int m_ts;
  bit m_run;
  bit m_done;
  bit m_err;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    tile_q.delete();
    part_q.delete();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  // Check this cycle's outputs, advance the model over the clock edge, move to the next cycle.
  task automatic step(output bit fired);
    logic [N_COLS*DATA_W-1:0] ed;
    logic [N_COLS-1:0]        ev;
    int nt;
    int d;
    bit exp_ready;
    bit fin;
    bit st;
    bit ne;
    #1;
    nt        = tile_q.size() / ELEMS;
    exp_ready = !bus.flush && (nt < 2);
    ed = '0;
    ev = '0;
    for (int k = 0; k < N_COLS; k++) begin
      d = cyc - m_ts - 1 - k;
      if (m_run && d >= 0 && d < TILE_ROWS) begin
        ev[k] = 1'b1;
        ed[k*DATA_W +: DATA_W] = tile_q[d*N_COLS + k];
      end
    end
    check_eq("col_data",    64'(bus.col_data),    64'(ed));
    check_eq("col_valid",   64'(bus.col_valid),   64'(ev));
    check_eq("pop_busy",    64'(bus.pop_busy),    64'(m_run));
    check_eq("pop_done",    64'(bus.pop_done),    64'(m_done));
    check_eq("pop_err",     64'(bus.pop_err),     64'(m_err));
    check_eq("tiles_avail", 64'(bus.tiles_avail), 64'(nt));
    check_eq("wr_ready",    64'(bus.wr_ready),    64'(exp_ready));

    fired = bus.wr_valid && exp_ready;
    if (bus.flush) begin
      model_clear();
    end else begin
      fin = m_run && (cyc - m_ts == DRAIN_LEN);
      st  = 1'b0;
      ne  = 1'b0;
      if (bus.pop_start) begin
        if (!m_run && nt > 0) st = 1'b1;
        else ne = 1'b1;
      end
      if (fired) begin
        part_q.push_back(bus.wr_data);
        if (part_q.size() == ELEMS) begin
          for (int i = 0; i < ELEMS; i++) tile_q.push_back(part_q[i]);
          part_q.delete();
        end
      end
      if (fin) begin
        for (int i = 0; i < ELEMS; i++) void'(tile_q.pop_front());
        m_run = 1'b0;
      end
      if (st) begin
        m_run = 1'b1;
        m_ts  = cyc;
      end
      m_done = fin;
      m_err  = ne;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.pop_start = 1'b0;
  endtask

  // Write n consecutive values starting at base, each held until accepted.
  task automatic write_seq(input int base, input int n);
    bit f;
    int g;
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = DATA_W'(base + i);
      f = 1'b0;
      g = 0;
      while (!f && g < 100) begin
        step(f);
        g++;
      end
      check_eq("wr_accept_wait", 64'(f), 64'd1);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic pop_once();
    bit f;
    bus.pop_start = 1'b1;
    step(f);
    bus.pop_start = 1'b0;
  endtask

  // Run until the modelled drain finishes, then one more cycle to see pop_done.
  task automatic run_out();
    bit f;
    int g;
    g = 0;
    while (m_run && g < 60) begin
      step(f);
      g++;
    end
    check_eq("drain_wait", 64'(m_run), 64'd0);
    step(f);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_col_data"},  64'(bus.col_data),    64'd0);
    check_eq({tag, "_col_valid"}, 64'(bus.col_valid),   64'd0);
    check_eq({tag, "_busy"},      64'(bus.pop_busy),    64'd0);
    check_eq({tag, "_done"},      64'(bus.pop_done),    64'd0);
    check_eq({tag, "_err"},       64'(bus.pop_err),     64'd0);
    check_eq({tag, "_tiles"},     64'(bus.tiles_avail), 64'd0);
    check_eq({tag, "_wr_ready"},  64'(bus.wr_ready),    64'd0);
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check_all_zero("rst_now");
    model_clear();
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    rst = 1'b0;
    #1;
    check_eq("rst_release_wr_ready", 64'(bus.wr_ready), 64'd1);
  endtask

  initial begin
    bit f;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_ts     = 0;
    rst      = 1'b0;
    idle_inputs();
    model_clear();
    #2;
    apply_reset();

    // pop with nothing committed
    pop_once();
    step(f);
    step(f);

    // single tile 0x00..0x0F then drain
    write_seq(8'h00, ELEMS);
    step(f);
    pop_once();
    run_out();

    // fill both banks, hold a 33rd element until a drain frees a bank
    write_seq(8'h40, 2 * ELEMS);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA5;
    for (int i = 0; i < 3; i++) step(f);
    bus.pop_start = 1'b1;
    step(f);
    bus.pop_start = 1'b0;
    write_seq(8'hA5, 1);
    run_out();
    write_seq(8'hB0, ELEMS - 1);
    pop_once();
    run_out();
    pop_once();
    run_out();

    // tile A drains while tile B loads, then back-to-back pop
    write_seq(8'h10, ELEMS);
    pop_once();
    write_seq(8'h60, ELEMS);
    run_out();
    pop_once();
    run_out();

    // reset three cycles into a drain
    write_seq(8'h70, ELEMS);
    pop_once();
    step(f);
    step(f);
    apply_reset();
    step(f);

    // flush a partial tile, then a clean tile 0x20..0x2F
    write_seq(8'h50, 5);
    bus.flush = 1'b1;
    step(f);
    bus.flush = 1'b0;
    write_seq(8'h20, ELEMS);
    pop_once();
    run_out();

    // random concurrent traffic with rare flushes
    for (int i = 0; i < 1500; i++) begin
      bus.wr_valid  = ($urandom_range(0, 99) < 60);
      bus.wr_data   = DATA_W'($urandom);
      bus.pop_start = ($urandom_range(0, 99) < 15);
      bus.flush     = ($urandom_range(0, 299) == 0);
      step(f);
    end
    idle_inputs();
    run_out();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_tile_fifo.md
Name: weight_tile_fifo

Overview:
- Parametrised successor to the fixed 3-column weight FIFO. Accepts a serial byte stream of weights and packs it into whole TILE_ROWS x N_COLS tiles.
- Holds up to two committed tiles in ping-pong banks.
- On command, drains one tile into the systolic array columns with diagonal skew: column k is delayed k cycles.
- Sits between the weight-load path and the MMU column inputs.

Parameters:
N_COLS, 4, number of systolic columns (>=2)
TILE_ROWS, 4, rows per tile (>=1)
DATA_W, 8, weight element width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of all banks and pointers
wr_valid  in  1  write element valid
wr_data  in  DATA_W  weight element
wr_ready  out  1  element accepted when wr_valid&&wr_ready
pop_start  in  1  request drain of oldest committed tile
col_data  out  N_COLS*DATA_W  column k at bits [k*DATA_W +: DATA_W]
col_valid  out  N_COLS  per-column valid
pop_busy  out  1  drain in progress
pop_done  out  1  one-cycle pulse, drain complete
pop_err  out  1  one-cycle pulse, pop_start rejected
tiles_avail  out  2  committed tiles, 0..2

Behaviour:
- Reset/flush values:
  - All outputs 0, except wr_ready=1 once out of reset.
  - Bank states free; fill bank=0, drain bank=0; element counter 0.
  - flush has priority over every other input in its cycle.
- Fill order:
  - Accepted element index e (0..TILE_ROWS*N_COLS-1) goes to row e/N_COLS, column e%N_COLS of the fill bank.
  - Accepting the last element commits the bank. In the following cycle tiles_avail increments and the fill bank toggles.
- wr_ready: combinational, 1 iff the fill bank is free.
  - tiles_avail=2 -> wr_ready=0.
  - Writes are never dropped silently.
- Drain FSM has two states: D_IDLE and D_RUN.
  - D_IDLE, pop_start, tiles_avail>0 -> D_RUN. Counter cnt=0 and pop_busy=1 from the next cycle.
  - D_IDLE, pop_start, tiles_avail=0 -> pop_err=1 next cycle; stay in D_IDLE.
  - D_RUN, pop_start -> ignored, pop_err=1 next cycle.
  - D_RUN: cnt counts 0..TILE_ROWS+N_COLS-2, then -> D_IDLE.
  - tiles_avail is sampled as a registered value. A tile committed in the same cycle as pop_start is not visible to it.
- Skew timing (registered outputs):
  - With pop_start accepted in cycle t, column k presents row r in cycle t+1+r+k, with col_valid[k]=1.
  - Otherwise col_valid[k]=0 and that column's data is 0.
  - Drain window is TILE_ROWS+N_COLS-1 cycles.
- Drain completion:
  - pop_done pulses in cycle t+TILE_ROWS+N_COLS; pop_busy falls in the same cycle.
  - In that same cycle the drained bank is freed, tiles_avail decrements, and the drain bank toggles.
  - wr_ready may rise combinationally in that cycle.
- Simultaneous commit and drain completion in one cycle: tiles_avail unchanged (+1-1).
- Fill and drain always use different banks whenever both are active. Concurrent load and drain is required: full ping-pong throughput.
- Reset mid-drain: everything returns to reset values immediately; the partial tile is discarded.
- flush mid-fill: the partial tile is discarded and the element counter returns to 0.

Decomposition:
- Package weight_tile_pkg holds:
  - drain_state_t enum {D_IDLE, D_RUN}
  - bank_state_t enum {B_FREE, B_FULL}
  - localparam helpers ELEMS=TILE_ROWS*N_COLS and DRAIN_LEN=TILE_ROWS+N_COLS-1, as functions of the parameters.
- One sub-module, tile_bank: a single bank of TILE_ROWS x N_COLS x DATA_W registers.
  - Write port: element write by (row, col).
  - Read port: per-column, row index per column.
  - Two instances.
  - Skew addressing (row = cnt-k, valid when 0<=cnt-k<TILE_ROWS) lives in the top level.

Test Plan (defaults N_COLS=4, TILE_ROWS=4, DATA_W=8):
- Write 0x00..0x0F, then pop_start at cycle t:
  - col0 = 00,04,08,0C in cycles t+1..t+4.
  - col3 = 03,07,0B,0F in cycles t+4..t+7.
  - pop_done in cycle t+8; tiles_avail goes 1->0.
- Write 32 elements with no pop:
  - tiles_avail=2 and wr_ready=0 after the 32nd element.
  - A 33rd element is held until pop_done, then accepted into bank 0.
- pop_start with tiles_avail=0 -> pop_err pulse; col_valid stays 0; state D_IDLE.
- Tile A committed, tile B loading during the drain of A:
  - A drains correctly; B commits.
  - Second pop_start immediately after pop_done drains B with no dead cycles beyond one.
- Assert rst at cycle t+3 of a drain -> all outputs 0 immediately, tiles_avail=0, wr_ready=1 after release.
- flush after 5 elements, then write 0x20..0x2F and pop -> col0 = 20,24,28,2C; no pre-flush data appears.
